dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, gives log2 of RAM depth in 32-bit words (1024 words).
REQ-002 Parameter WAIT_CYCLES, default 1, gives wait states between accept and response, legal range 0..15.
REQ-003 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 i_rst  in  1  reset, asynchronous, active-high.
REQ-005 i_valid  in  1  request present.
REQ-006 o_ready  out  1  controller can accept a request.
REQ-007 i_st_ld_sel  in  1  1 = store, 0 = load.
REQ-008 i_addr  in  30  word address, byte address bits [31:2].
REQ-009 i_st_data  in  32  store data.
REQ-010 i_mask  in  4  byte-enable for stores; bit n enables byte lane n (bits [8n+7:8n]).
REQ-011 o_ld_data  out  32  load data, full word.
REQ-012 o_done  out  1  one-cycle completion pulse, for loads and stores.
REQ-013 o_err  out  1  out-of-range pulse; present only when DMEM_RANGE_CHK_EN is defined.

Function
REQ-014 A request is accepted on a rising edge where i_valid && o_ready; i_st_ld_sel, i_addr, i_st_data and i_mask are latched there.
REQ-015 The FSM has states IDLE, WAIT and RESP; o_ready = 1 only in IDLE.
REQ-016 Transitions: on accept, IDLE goes to WAIT, or straight to RESP if WAIT_CYCLES = 0.
REQ-017 WAIT lasts exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter loaded at accept, then goes to RESP.
REQ-018 RESP lasts one cycle, then goes to IDLE; a new request is never accepted in the RESP cycle.
REQ-019 Latency: accept at edge T gives o_done = 1 in cycle T+WAIT_CYCLES+1 and o_ready = 1 in cycle T+WAIT_CYCLES+2.
REQ-020 Load: o_ld_data is registered on the edge entering RESP with RAM[addr]; i_mask is ignored.
REQ-021 o_ld_data holds its value until the next load reaches RESP; stores never change it.
REQ-022 Store: on the edge leaving RESP, only byte lanes with i_mask bit = 1 are written; mask 4'b0000 writes nothing but still produces o_done.
REQ-023 A store is visible to any load accepted after the store's o_done.
REQ-024 RAM index = latched addr[DEPTH_LOG2-1:0]; upper address bits are handled per REQ-030/REQ-031.
REQ-025 i_valid is ignored outside IDLE; input changes after accept have no effect on the request in flight.

Reset
REQ-026 While i_rst = 1: FSM = IDLE, wait counter = 0, o_ready = 1, o_done = 0, o_ld_data = 32'h0, o_err = 0.
REQ-027 Reset mid-operation abandons the request; a store not yet past RESP is never written.
REQ-028 RAM contents are not reset.
REQ-029 The first request can be accepted on the first rising edge after i_rst deasserts.

Configuration
REQ-030 DMEM_RANGE_CHK_EN defined: latched addr with any nonzero bit above DEPTH_LOG2-1 is out of range.
- o_err pulses together with o_done.
- Out-of-range store writes nothing.
- Out-of-range load returns 32'h0.
REQ-031 DMEM_RANGE_CHK_EN undefined: o_err port absent, upper address bits ignored, so the address wraps modulo 2^DEPTH_LOG2.

Verification
REQ-032 Reset then store addr 5, data 32'hDEADBEEF, mask 4'hF, then load addr 5 (WAIT_CYCLES=1) -> o_done 2 cycles after each accept; load returns 32'hDEADBEEF.
REQ-033 Store addr 5, data 32'h11223344, mask 4'b0101, over 32'hDEADBEEF, then load addr 5 -> 32'hDE22BE44.
REQ-034 WAIT_CYCLES=0, i_valid held high with back-to-back loads -> accept every 2nd cycle; o_done in the cycle after each accept.
REQ-035 Assert i_rst during WAIT of a store to addr 7 holding old value 32'h0 -> outputs at reset values; later load addr 7 returns 32'h0.
REQ-036 DEPTH_LOG2=10, store 32'hA5A5A5A5 to addr 30'h400:
- with DMEM_RANGE_CHK_EN: o_err = 1 with o_done, addr 0 unchanged, load 30'h400 returns 32'h0;
- without DMEM_RANGE_CHK_EN: load addr 0 returns 32'hA5A5A5A5.
REQ-037 Toggle i_valid and i_addr during WAIT -> no extra accept, and the latched request completes unchanged.

Source files
------------

// File: rtl/dmem_ctrl_if.sv
// Request/response bundle for the data-memory controller.
// o_err exists only when DMEM_RANGE_CHK_EN is defined.
interface dmem_ctrl_if;
  logic        i_valid;
  logic        o_ready;
  logic        i_st_ld_sel;
  logic [29:0] i_addr;
  logic [31:0] i_st_data;
  logic [3:0]  i_mask;
  logic [31:0] o_ld_data;
  logic        o_done;
`ifdef DMEM_RANGE_CHK_EN
  logic        o_err;

  modport master (
    output i_valid, i_st_ld_sel, i_addr,
    output i_st_data, i_mask,
    input  o_ready, o_ld_data, o_done, o_err
  );

  modport slave (
    input  i_valid, i_st_ld_sel, i_addr,
    input  i_st_data, i_mask,
    output o_ready, o_ld_data, o_done, o_err
  );
`else
  modport master (
    output i_valid, i_st_ld_sel, i_addr,
    output i_st_data, i_mask,
    input  o_ready, o_ld_data, o_done
  );

  modport slave (
    input  i_valid, i_st_ld_sel, i_addr,
    input  i_st_data, i_mask,
    output o_ready, o_ld_data, o_done
  );
`endif
endinterface

// File: rtl/dmem_ctrl.sv
// Single-port data memory controller with fixed wait states.
// Define DMEM_RANGE_CHK_EN to flag and suppress out-of-range accesses.
module dmem_ctrl #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  dmem_ctrl_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  logic [31:0] mem [DEPTH];

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  st_q, st_d;
  logic [31:0]           data_q, data_d;
  logic [3:0]            mask_q, mask_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic [31:0]           ld_q, ld_d;
  logic                  go_resp;
  logic                  we;
`ifdef DMEM_RANGE_CHK_EN
  logic                  oor_q, oor_d;
  logic                  err_q, err_d;
`endif

  // Next-state, request latching and registered-output computation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    st_d    = st_q;
    data_d  = data_q;
    mask_d  = mask_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    ld_d    = ld_q;
    go_resp = 1'b0;
`ifdef DMEM_RANGE_CHK_EN
    oor_d   = oor_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_valid) begin
          idx_d  = bus.i_addr[DEPTH_LOG2-1:0];
          st_d   = bus.i_st_ld_sel;
          data_d = bus.i_st_data;
          mask_d = bus.i_mask;
`ifdef DMEM_RANGE_CHK_EN
          oor_d  = (bus.i_addr >> DEPTH_LOG2) != '0;
`endif
          if (WAIT_CYCLES == 0) begin
            go_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
            ready_d = 1'b0;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
        ready_d = 1'b1;
      end
    endcase
    // Entering RESP: raise done and capture load data.
    // idx_d is the incoming address when WAIT is skipped.
    if (go_resp) begin
      state_d = S_RESP;
      ready_d = 1'b0;
      done_d  = 1'b1;
`ifdef DMEM_RANGE_CHK_EN
      err_d   = oor_d;
      if (!st_d) ld_d = oor_d ? 32'h0 : mem[idx_d];
`else
      if (!st_d) ld_d = mem[idx_d];
`endif
    end
  end

  // Controller state and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      st_q    <= 1'b0;
      data_q  <= 32'h0;
      mask_q  <= 4'h0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      ld_q    <= 32'h0;
`ifdef DMEM_RANGE_CHK_EN
      oor_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      st_q    <= st_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      ld_q    <= ld_d;
`ifdef DMEM_RANGE_CHK_EN
      oor_q   <= oor_d;
      err_q   <= err_d;
`endif
    end
  end

  // Stores commit on the edge leaving RESP, never under reset
`ifdef DMEM_RANGE_CHK_EN
  assign we = (state_q == S_RESP) && st_q && !oor_q && !i_rst;
`else
  assign we = (state_q == S_RESP) && st_q && !i_rst;
`endif

  // Byte-lane masked RAM write; contents survive reset
  always_ff @(posedge i_clk) begin
    if (we) begin
      for (int n = 0; n < 4; n++) begin
        if (mask_q[n]) mem[idx_q][8*n +: 8] <= data_q[8*n +: 8];
      end
    end
  end

  assign bus.o_ready   = ready_q;
  assign bus.o_done    = done_q;
  assign bus.o_ld_data = ld_q;
`ifdef DMEM_RANGE_CHK_EN
  assign bus.o_err     = err_q;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: randomized loads/stores
// against an array model, plus reset and zero-wait checks.
module tb_dmem_ctrl;

  localparam int DL = 10;
  localparam int W  = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  dmem_ctrl_if bus ();
  dmem_ctrl_if bus0 ();

  dmem_ctrl #(.DEPTH_LOG2(DL), .WAIT_CYCLES(W)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  dmem_ctrl #(.DEPTH_LOG2(DL), .WAIT_CYCLES(0)) u_dut0 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus0.slave)
  );

  typedef struct {
    bit          is_st;
    logic [31:0] exp_ld;
    bit          exp_err;
    int          acc;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mdl [1024];
  logic [31:0] last_ld = 32'h0;
  int          cyc   = 0;
  int          tests = 0;
  int          fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Monitor: pops the scoreboard on every completion pulse
  always @(negedge clk) begin
    if (!rst && bus.o_done) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_done: got done with empty queue");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("latency", 32'(cyc - e.acc), 32'(W));
        check("ready_in_resp", {31'b0, bus.o_ready}, 32'h0);
        check(e.is_st ? "st_ld_hold" : "ld_data",
              bus.o_ld_data, e.exp_ld);
`ifdef DMEM_RANGE_CHK_EN
        check("err", {31'b0, bus.o_err}, {31'b0, e.exp_err});
`endif
      end
    end
  end

  task automatic issue(input bit st, input logic [29:0] a,
                       input logic [31:0] d, input logic [3:0] m,
                       input bit use_want, input logic [31:0] want);
    int   n = 0;
    int   idx;
    bit   oor;
    exp_t e;
    @(negedge clk);
    bus.i_valid     = 1'b1;
    bus.i_st_ld_sel = st;
    bus.i_addr      = a;
    bus.i_st_data   = d;
    bus.i_mask      = m;
    while (!bus.o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got ready 0 want 1");
      bus.i_valid = 1'b0;
      return;
    end
    idx = int'(a) % 1024;
`ifdef DMEM_RANGE_CHK_EN
    oor = a >= 30'd1024;
`else
    oor = 1'b0;
`endif
    e.is_st   = st;
    e.exp_err = oor;
    if (st) begin
      if (!oor) begin
        for (int l = 0; l < 4; l++)
          if (m[l]) mdl[idx][8*l +: 8] = d[8*l +: 8];
      end
      e.exp_ld = last_ld;
    end else begin
      e.exp_ld = oor ? 32'h0 : mdl[idx];
      if (use_want) e.exp_ld = want;
      last_ld = e.exp_ld;
    end
    @(posedge clk);
    #1;
    e.acc = cyc;
    sbq.push_back(e);
    // Garbage while busy must not disturb the request in flight
    bus.i_valid   = 1'($urandom);
    bus.i_addr    = 30'($urandom);
    bus.i_st_data = $urandom;
    bus.i_mask    = 4'($urandom);
  endtask

  task automatic quiesce();
    int n = 0;
    @(negedge clk);
    bus.i_valid = 1'b0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending want 0",
               sbq.size());
    end
    @(negedge clk);
  endtask

  initial begin
    bus.i_valid      = 1'b0;
    bus.i_st_ld_sel  = 1'b0;
    bus.i_addr       = '0;
    bus.i_st_data    = '0;
    bus.i_mask       = '0;
    bus0.i_valid     = 1'b0;
    bus0.i_st_ld_sel = 1'b0;
    bus0.i_addr      = '0;
    bus0.i_st_data   = '0;
    bus0.i_mask      = '0;

    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, bus.o_ready}, 32'h1);
    check("rst_done", {31'b0, bus.o_done}, 32'h0);
    check("rst_ld", bus.o_ld_data, 32'h0);
`ifdef DMEM_RANGE_CHK_EN
    check("rst_err", {31'b0, bus.o_err}, 32'h0);
`endif

    // Zero-wait instance: first edge after reset accepts,
    // then back-to-back loads accept every second cycle.
    rst = 1'b0;
    bus0.i_valid     = 1'b1;
    bus0.i_st_ld_sel = 1'b1;
    bus0.i_addr      = 30'd3;
    bus0.i_st_data   = 32'hCAFE0001;
    bus0.i_mask      = 4'hF;
    @(negedge clk);
    check("w0_store_done", {31'b0, bus0.o_done}, 32'h1);
    bus0.i_st_ld_sel = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("w0_done_pattern", {31'b0, bus0.o_done},
            32'(i % 2));
      if (bus0.o_done)
        check("w0_ld_data", bus0.o_ld_data, 32'hCAFE0001);
    end
    bus0.i_valid = 1'b0;

    // Fill the working window so every load has a known value
    for (int i = 0; i < 32; i++)
      issue(1'b1, 30'(i), $urandom, 4'hF, 1'b0, '0);

    issue(1'b1, 30'd5, 32'hDEADBEEF, 4'hF, 1'b0, '0);
    issue(1'b0, 30'd5, '0, 4'h0, 1'b1, 32'hDEADBEEF);
    issue(1'b1, 30'd5, 32'h11223344, 4'b0101, 1'b0, '0);
    issue(1'b0, 30'd5, '0, 4'hF, 1'b1, 32'hDE22BE44);
    issue(1'b1, 30'd5, 32'hFFFFFFFF, 4'b0000, 1'b0, '0);
    issue(1'b0, 30'd5, '0, 4'h0, 1'b1, 32'hDE22BE44);

    issue(1'b1, 30'd0, 32'h12345678, 4'hF, 1'b0, '0);
    issue(1'b1, 30'h400, 32'hA5A5A5A5, 4'hF, 1'b0, '0);
`ifdef DMEM_RANGE_CHK_EN
    issue(1'b0, 30'd0, '0, 4'h0, 1'b1, 32'h12345678);
    issue(1'b0, 30'h400, '0, 4'h0, 1'b1, 32'h0);
`else
    issue(1'b0, 30'd0, '0, 4'h0, 1'b1, 32'hA5A5A5A5);
`endif

    for (int k = 0; k < 200; k++) begin
      int b;
      int al;
      b  = int'($urandom % 32);
      al = ($urandom % 4 == 0) ? 1 + int'($urandom % 3) : 0;
      issue(1'($urandom), 30'(b + al * 1024), $urandom,
            4'($urandom), 1'b0, '0);
      if ($urandom % 4 == 0) begin
        repeat ($urandom % 3) begin
          @(negedge clk);
          bus.i_valid = 1'b0;
        end
      end
    end

    // Reset in the middle of a store abandons it
    issue(1'b1, 30'd7, 32'h0, 4'hF, 1'b0, '0);
    quiesce();
    begin
      int n = 0;
      while (!bus.o_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    bus.i_valid     = 1'b1;
    bus.i_st_ld_sel = 1'b1;
    bus.i_addr      = 30'd7;
    bus.i_st_data   = 32'hFFFFFFFF;
    bus.i_mask      = 4'hF;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", {31'b0, bus.o_ready}, 32'h1);
    check("mid_rst_done", {31'b0, bus.o_done}, 32'h0);
    check("mid_rst_ld", bus.o_ld_data, 32'h0);
`ifdef DMEM_RANGE_CHK_EN
    check("mid_rst_err", {31'b0, bus.o_err}, 32'h0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_ld = 32'h0;
    issue(1'b0, 30'd7, '0, 4'h0, 1'b1, 32'h0);
    quiesce();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
